// File: rtl/midi_voice_allocator_if.sv
// FIFO read-side bus between the MIDI byte FIFO and the voice allocator.
//   fifo_dout  : byte popped by the previous fifo_rd_en pulse
//   fifo_empty : FIFO has nothing to pop
//   fifo_rd_en : pop request, one-cycle pulse
// master = allocator (pops), slave = FIFO (supplies data).
interface midi_voice_allocator_if;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd_en;

  modport master (input fifo_dout, input fifo_empty, output fifo_rd_en);
  modport slave  (output fifo_dout, output fifo_empty, input fifo_rd_en);
endinterface

// File: rtl/midi_voice_allocator.sv
// MIDI Note-On/Note-Off parser and polyphonic voice allocator.
// Pops one byte at a time from the FIFO (FETCH/CAPTURE/PARSE), and on a
// complete note message updates the voice bank (registered into EXEC).
// Ports:
//   clk, reset            : clock, async active-high reset
//   fifo                  : FIFO read bus (master side)
//   voice_gate/note/vel   : per-voice state, voice v at bit v / [7v+6:7v]
//   evt_valid/on/voice/note : one-cycle event strobe and its payload
module midi_voice_allocator #(
  parameter int NUM_VOICES   = 4,
  parameter int MIDI_CHANNEL = 0,
  parameter int VW           = $clog2(NUM_VOICES)
) (
  input  logic                    clk,
  input  logic                    reset,
  midi_voice_allocator_if.master  fifo,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic                    evt_valid,
  output logic                    evt_on,
  output logic [VW-1:0]           evt_voice,
  output logic [6:0]              evt_note
);

  typedef enum logic [1:0] {S_FETCH, S_CAPTURE, S_PARSE, S_EXEC} state_t;

  state_t                        r_state, w_state_nxt;
  logic                          w_rd_en;
  logic [7:0]                    r_byte;
  logic                          r_rs_valid, r_rs_on, r_dcnt;
  logic [6:0]                    r_note;
  logic [NUM_VOICES-1:0]         r_gate;
  logic [NUM_VOICES-1:0][6:0]    r_vnote, r_vvel;
  logic [NUM_VOICES-1:0][VW-1:0] r_rank;
  logic                          r_evt_valid, r_evt_on;
  logic [VW-1:0]                 r_evt_voice;
  logic [6:0]                    r_evt_note;

  // byte classification of the captured byte
  logic w_is_rt, w_is_chan_note, w_complete, w_note_on;
  assign w_is_rt        = (r_byte >= 8'hF8);
  assign w_is_chan_note = (r_byte[7:5] == 3'b100) && (r_byte[3:0] == MIDI_CHANNEL[3:0]);
  assign w_complete     = !r_byte[7] && r_rs_valid && r_dcnt;
  // Note-On with velocity 0 is a release
  assign w_note_on      = r_rs_on && (r_byte[6:0] != 7'd0);

  // voice search: sounding voice with same note, lowest free voice, oldest voice
  logic          w_hit, w_free;
  logic [VW-1:0] w_hit_idx, w_free_idx, w_old_idx, w_sel;
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    w_old_idx  = '0;
    // descending scan so the lowest matching index wins
    for (int v = NUM_VOICES-1; v >= 0; v--) begin
      if (r_gate[v] && (r_vnote[v] == r_note)) begin
        w_hit     = 1'b1;
        w_hit_idx = VW'(v);
      end
      if (!r_gate[v]) begin
        w_free     = 1'b1;
        w_free_idx = VW'(v);
      end
      if (r_rank[v] == VW'(NUM_VOICES-1)) w_old_idx = VW'(v);
    end
    w_sel = w_hit ? w_hit_idx : (w_free ? w_free_idx : w_old_idx);
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    case (r_state)
      S_FETCH: if (!fifo.fifo_empty) begin
        w_rd_en     = 1'b1;
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: w_state_nxt = S_PARSE;
      S_PARSE:   w_state_nxt = w_complete ? S_EXEC : S_FETCH;
      S_EXEC:    w_state_nxt = S_FETCH;
      default:   w_state_nxt = S_FETCH;
    endcase
  end

  // pop is combinational from FETCH; masked during reset so outputs read 0
  assign fifo.fifo_rd_en = w_rd_en && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  // Parser and voice bank. Voice updates are registered on the PARSE->EXEC
  // edge so they (and evt_valid) are visible during the EXEC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte      <= '0;
      r_rs_valid  <= 1'b0;
      r_rs_on     <= 1'b0;
      r_dcnt      <= 1'b0;
      r_note      <= '0;
      r_gate      <= '0;
      r_vnote     <= '0;
      r_vvel      <= '0;
      for (int v = 0; v < NUM_VOICES; v++) r_rank[v] <= VW'(v);
      r_evt_valid <= 1'b0;
      r_evt_on    <= 1'b0;
      r_evt_voice <= '0;
      r_evt_note  <= '0;
    end else begin
      r_evt_valid <= 1'b0;
      if (r_state == S_CAPTURE) r_byte <= fifo.fifo_dout;
      if (r_state == S_PARSE) begin
        if (r_byte[7]) begin
          // realtime bytes leave running status and data count untouched
          if (!w_is_rt) begin
            r_rs_valid <= w_is_chan_note;
            r_rs_on    <= r_byte[4];
            r_dcnt     <= 1'b0;
          end
        end else if (r_rs_valid) begin
          if (!r_dcnt) begin
            r_note <= r_byte[6:0];
            r_dcnt <= 1'b1;
          end else begin
            r_dcnt <= 1'b0;
            if (w_note_on) begin
              r_gate[w_sel]  <= 1'b1;
              r_vnote[w_sel] <= r_note;
              r_vvel[w_sel]  <= r_byte[6:0];
              // move chosen voice to youngest; younger voices age by one
              for (int v = 0; v < NUM_VOICES; v++) begin
                if (VW'(v) == w_sel)              r_rank[v] <= '0;
                else if (r_rank[v] < r_rank[w_sel]) r_rank[v] <= r_rank[v] + 1'b1;
              end
              r_evt_valid <= 1'b1;
              r_evt_on    <= 1'b1;
              r_evt_voice <= w_sel;
              r_evt_note  <= r_note;
            end else if (w_hit) begin
              r_gate[w_hit_idx] <= 1'b0;
              r_evt_valid <= 1'b1;
              r_evt_on    <= 1'b0;
              r_evt_voice <= w_hit_idx;
              r_evt_note  <= r_note;
            end
          end
        end
      end
    end
  end

  assign voice_gate = r_gate;
  assign voice_note = r_vnote;
  assign voice_vel  = r_vvel;
  assign evt_valid  = r_evt_valid;
  assign evt_on     = r_evt_on;
  assign evt_voice  = r_evt_voice;
  assign evt_note   = r_evt_note;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: directed scenarios plus a randomized byte
// stream, checked against a message-level model (age list, note lists).
module tb_midi_voice_allocator;
  localparam int N  = 4;
  localparam int CH = 0;
  localparam int VW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  midi_voice_allocator_if bus();
  logic [N-1:0]   voice_gate;
  logic [7*N-1:0] voice_note, voice_vel;
  logic           evt_valid, evt_on;
  logic [VW-1:0]  evt_voice;
  logic [6:0]     evt_note;

  midi_voice_allocator #(.NUM_VOICES(N), .MIDI_CHANNEL(CH)) dut (
    .clk(clk), .reset(reset), .fifo(bus.master),
    .voice_gate(voice_gate), .voice_note(voice_note), .voice_vel(voice_vel),
    .evt_valid(evt_valid), .evt_on(evt_on), .evt_voice(evt_voice), .evt_note(evt_note)
  );

  // FIFO: initial block writes mem/wr_cnt, this side pops
  logic [7:0] mem [0:1023];
  int wr_cnt = 0;
  int rd_cnt = 0;
  always_comb bus.fifo_empty = (wr_cnt == rd_cnt);
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_dout <= mem[rd_cnt[9:0]];
      rd_cnt <= rd_cnt + 1;
    end
  end

  // event monitor
  typedef struct { int on; int voice; int note; int lat; } ev_t;
  ev_t obs_q[$];
  int  cyc = 0, last_rd = 0, viol = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    ev_t e;
    if (bus.fifo_empty && bus.fifo_rd_en) viol <= viol + 1;
    if (evt_valid) begin
      e.on = int'(evt_on); e.voice = int'(evt_voice); e.note = int'(evt_note);
      e.lat = cyc - last_rd;
      obs_q.push_back(e);
    end
    if (bus.fifo_rd_en) last_rd <= cyc;
  end

  // reference model
  int  m_gate[N], m_note[N], m_vel[N];
  int  age_q[$];               // front = most recently assigned
  bit  m_rs_valid, m_rs_on, m_dcnt;
  int  m_first;
  ev_t exp_q[$];
  int  obs_rd = 0, exp_rd = 0;
  int  total = 0, bad = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic m_reset();
    age_q.delete();
    for (int v = 0; v < N; v++) begin
      m_gate[v] = 0; m_note[v] = 0; m_vel[v] = 0; age_q.push_back(v);
    end
    m_rs_valid = 0; m_rs_on = 0; m_dcnt = 0; m_first = 0;
  endtask

  task automatic m_note_msg(bit on, int note, int vel);
    int sel = -1;
    ev_t e;
    for (int v = 0; v < N; v++) if (sel < 0 && m_gate[v] == 1 && m_note[v] == note) sel = v;
    if (on) begin
      for (int v = 0; v < N; v++) if (sel < 0 && m_gate[v] == 0) sel = v;
      if (sel < 0) sel = age_q[$];
      m_gate[sel] = 1; m_note[sel] = note; m_vel[sel] = vel;
      for (int i = 0; i < age_q.size(); i++) if (age_q[i] == sel) begin age_q.delete(i); break; end
      age_q.push_front(sel);
    end else begin
      if (sel < 0) return;
      m_gate[sel] = 0;
    end
    e.on = int'(on); e.voice = sel; e.note = note; e.lat = 3;
    exp_q.push_back(e);
  endtask

  task automatic m_byte(int b);
    if (b >= 'hF8) return;
    if (b >= 'hF0) m_rs_valid = 0;
    else if (b >= 'h80) begin
      if (((b >> 4) == 8 || (b >> 4) == 9) && (b & 15) == CH) begin
        m_rs_valid = 1; m_rs_on = ((b >> 4) == 9); m_dcnt = 0;
      end else m_rs_valid = 0;
    end else if (m_rs_valid) begin
      if (!m_dcnt) begin m_first = b; m_dcnt = 1; end
      else begin m_dcnt = 0; m_note_msg(m_rs_on && b != 0, m_first, b); end
    end
  endtask

  task automatic put(int b);
    mem[wr_cnt[9:0]] = 8'(b);
    wr_cnt++;
    m_byte(b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_all(string tag);
    int budget = 2000;
    int no, ne;
    while (wr_cnt != rd_cnt && budget > 0) begin @(negedge clk); budget--; end
    repeat (6) @(negedge clk);
    chk({tag, "_drain"}, 32'(rd_cnt), 32'(wr_cnt));
    for (int v = 0; v < N; v++) begin
      chk($sformatf("%s_gate%0d", tag, v), 32'(voice_gate[v]), 32'(m_gate[v]));
      chk($sformatf("%s_note%0d", tag, v), 32'(voice_note[7*v +: 7]), 32'(m_note[v]));
      chk($sformatf("%s_vel%0d", tag, v), 32'(voice_vel[7*v +: 7]), 32'(m_vel[v]));
    end
    no = obs_q.size() - obs_rd;
    ne = exp_q.size() - exp_rd;
    chk({tag, "_nevt"}, 32'(no), 32'(ne));
    for (int i = 0; i < no && i < ne; i++) begin
      chk($sformatf("%s_ev%0d_on", tag, i), 32'(obs_q[obs_rd+i].on), 32'(exp_q[exp_rd+i].on));
      chk($sformatf("%s_ev%0d_voice", tag, i), 32'(obs_q[obs_rd+i].voice), 32'(exp_q[exp_rd+i].voice));
      chk($sformatf("%s_ev%0d_note", tag, i), 32'(obs_q[obs_rd+i].note), 32'(exp_q[exp_rd+i].note));
      chk($sformatf("%s_ev%0d_lat", tag, i), 32'(obs_q[obs_rd+i].lat), 32'(exp_q[exp_rd+i].lat));
    end
    obs_rd = obs_q.size();
    exp_rd = exp_q.size();
    chk({tag, "_rd_while_empty"}, 32'(viol), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    m_reset();
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_gate", 32'(voice_gate), 32'd0);
    chk("rst_note", 32'(voice_note), 32'd0);
    chk("rst_evt", 32'(evt_valid), 32'd0);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_rd_en", 32'(bus.fifo_rd_en), 32'd0);

    // 1: basic note-on
    put('h90); put('h3C); put('h64);
    check_all("t1");
    chk("t1_gate_lit", 32'(voice_gate), 32'h1);
    chk("t1_note_lit", 32'(voice_note[6:0]), 32'h3C);
    chk("t1_vel_lit", 32'(voice_vel[6:0]), 32'h64);

    // 2: running status, then retrigger
    do_reset();
    put('h90); put('h3C); put('h64); put('h40); put('h50);
    check_all("t2a");
    put('h3C); put('h7F);
    check_all("t2b");
    chk("t2_gate_lit", 32'(voice_gate), 32'h3);
    chk("t2_vel0_lit", 32'(voice_vel[6:0]), 32'h7F);

    // 3: steal the oldest voice
    do_reset();
    put('h90);
    for (int n = 60; n <= 64; n++) begin put(n); put(40); end
    check_all("t3");
    chk("t3_gate_lit", 32'(voice_gate), 32'hF);
    chk("t3_voice_lit", 32'(evt_voice), 32'd0);
    chk("t3_note_lit", 32'(voice_note[6:0]), 32'd64);

    // 4: release via velocity 0 and 0x8n, including non-matching note-offs
    do_reset();
    put('h90); put('h3C); put('h64);
    put('h90); put('h3C); put('h00);
    put('h80); put('h3C); put('h40);
    put('h80); put('h7F); put('h00);
    check_all("t4");
    chk("t4_gate_lit", 32'(voice_gate), 32'h0);
    chk("t4_evt_on_lit", 32'(evt_on), 32'd0);

    // 5: filtering
    do_reset();
    put('h90); put('h3C); put('hF8); put('h64);
    put('h91); put('h3C); put('h64); put('h3D); put('h64);
    put('hF0); put('h3C); put('h64);
    put('hA0); put('h3E); put('h64);
    check_all("t5");

    // 6: reset in CAPTURE of a partial message
    do_reset();
    put('h90); put('h3C); put('h64);
    check_all("t6a");
    put('h90); put('h3C);
    budget = 200;
    while (wr_cnt != rd_cnt && budget > 0) begin @(negedge clk); budget--; end
    chk("t6_popped", 32'(rd_cnt), 32'(wr_cnt));
    reset = 1'b1;
    m_reset();
    #1;
    chk("t6_rst_gate", 32'(voice_gate), 32'd0);
    chk("t6_rst_note", 32'(voice_note), 32'd0);
    chk("t6_rst_vel", 32'(voice_vel), 32'd0);
    chk("t6_rst_evt", {28'd0, evt_valid, evt_on, evt_voice}, 32'd0);
    chk("t6_rst_evt_note", 32'(evt_note), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    put('h64); put('h3C); put('h64);
    check_all("t6b");

    // randomized stream
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int r, b;
      r = int'($urandom_range(0, 11));
      case (r)
        0, 1:    b = 'h90;
        2:       b = 'h80;
        3: begin
          case ($urandom_range(0, 4))
            0: b = 'h91;
            1: b = 'hF8;
            2: b = 'hF0;
            3: b = 'hA0;
            default: b = 'hFE;
          endcase
        end
        default: b = ($urandom_range(0, 7) == 0) ? 0 : 'h3C + int'($urandom_range(0, 5));
      endcase
      put(b);
      if (i % 25 == 24) check_all($sformatf("rnd%0d", i));
    end
    check_all("rnd_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
